poly_voice_allocator: RTL and testbench
=======================================

// Module: poly_voice_allocator
// PURPOSE
// Parametrised N-voice allocator and successor to the single-voice synth top. Accepts note-on/note-off events
// from the PS register bank over a valid/ready handshake and assigns each event to one of NUM_VOICES voice
// slots: free voice first, then oldest released, then oldest gated (steal). Per-voice fccw and gate outputs
// drive per-voice ddfs carrier words and adsr_rt start inputs; per-voice adsr idle flags return as voice_idle.
// PARAMETERS
// NUM_VOICES       4   voice slots, 2..16
// PHASE_ACC_WIDTH  30  width of carrier ctrl word, matches ddfs
// NOTE_W           7   note number width (MIDI 0..127)
// AGE_W            8   per-voice age counter width, saturating
// PORTS
// clk          in   1                          system clock
// reset        in   1                          asynchronous, active-low reset
// ev_valid     in   1                          event valid
// ev_ready     out  1                          event ready; (state==IDLE) && !all_notes_off
// ev_on        in   1                          1 = note-on, 0 = note-off
// ev_note      in   NOTE_W                     note number
// ev_fccw      in   PHASE_ACC_WIDTH            carrier word for note-on (ignored on note-off)
// all_notes_off in  1                          panic request, level
// voice_idle   in   NUM_VOICES                 per-voice envelope idle (adsr_rt adsr_idle)
// voice_gate   out  NUM_VOICES                 per-voice gate, level
// voice_fccw   out  [NUM_VOICES][PHASE_ACC_W]  per-voice carrier word (packed 2-D)
// voice_note   out  [NUM_VOICES][NOTE_W]       per-voice current note
// steal_cnt    out  16                         voices stolen since reset, saturating at 16'hFFFF
// BEHAVIOUR
// - Reset (async, reset==0): all gates 0, fccw 0, notes 0, ages 0, steal_cnt 0, FSM IDLE. ev_ready reads 1 in reset.
// - Handshake: event accepted on the rising clk edge with ev_valid && ev_ready; ev_* latched; FSM IDLE->SCAN.
// - SCAN: one voice per cycle, idx 0..NUM_VOICES-1; running candidates:
//   match (gate=1 && note==ev_note), free (gate=0 && idle=1), rel (gate=0 && idle=0, max age),
//   old (gate=1, max age). Ties -> lowest index (strict > on age). After idx==NUM_VOICES-1 -> COMMIT.
// - COMMIT, note-on: target = match, else free, else rel, else old (steal, steal_cnt+1 sat).
//   Free target: gate=1, fccw/note load this cycle; -> IDLE.
//   Match/rel/old target: gate=0, fccw/note load; -> RETRIG. RETRIG: gate=1; -> IDLE.
//   Guarantees the one-cycle low gap adsr_rt needs to restart its attack.
//   Ages: on every note-on commit all other voices age+1 (saturate at 2^AGE_W-1); target age=0.
// - COMMIT, note-off: match -> gate=0, fccw/note held for release tail; no match -> event dropped, no change. -> IDLE.
// - Latency, accept edge to gate rising: NUM_VOICES+1 cycles (free), NUM_VOICES+2 (retrigger/steal).
//   Next event accepted earliest the cycle after return to IDLE.
// - all_notes_off: highest priority. In any state, next edge clears all gates and returns FSM to IDLE;
//   in-flight event discarded; ages reset to 0; fccw/note held. ev_ready=0 while asserted.
// - voice_idle used only during SCAN; changes mid-scan are seen only for idx not yet visited.
// - Duplicate note-on for a note already gated is always retriggered, never allocated twice.
// STRUCTURE
// - synth_pkg (shared): SINE..NOISE wave-type constants, alloc_state_t enum {IDLE,SCAN,COMMIT,RETRIG},
//   voice_t struct {gate, note, fccw, age}.
// - No sub-module: scan, candidate registers and voice array stay in one always_ff plus next-state always_comb.
// - synth top instantiates NUM_VOICES ddfs + adsr_rt, indexed by voice, fed by this block.
// TESTING (NUM_VOICES=4)
// 1 Reset mid-SCAN (reset=0 for 1 cycle) -> all gates 0, steal_cnt 0, ev_ready 1, idle accepted on next event.
// 2 Note-on 60/fccw 'h1000, all idle -> voice0 gate 1 five cycles after accept; voice_note[0]=60; note-off 60 -> gate[0]=0.
// 3 Four note-ons 60,62,64,65 then 67, voice_idle=0 -> voice0 (oldest) gate low 1 cycle, then high with note 67; steal_cnt=1.
// 4 Note-on 60 twice -> second event retriggers voice0 (gate 1->0->1), voices1..3 stay 0.
// 5 Note-off 70 with no voice holding 70 -> no output change; ev_ready returns 1 after NUM_VOICES+1 cycles.
// 6 all_notes_off pulsed during SCAN of note-on 72 -> all gates 0 next cycle, note 72 never allocated.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared synth types: wave selectors, voice allocator FSM states, per-voice record.
// Widths below are the defaults used across the synth top.
package synth_pkg;

    typedef enum logic [2:0] {
        SINE,
        SQUARE,
        SAW,
        TRIANGLE,
        NOISE
    } wave_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT,
        RETRIG
    } alloc_state_t;

    localparam int VOICE_PHASE_W = 30;
    localparam int VOICE_NOTE_W  = 7;
    localparam int VOICE_AGE_W   = 8;

    typedef struct packed {
        logic                     gate;
        logic [VOICE_NOTE_W-1:0]  note;
        logic [VOICE_PHASE_W-1:0] fccw;
        logic [VOICE_AGE_W-1:0]   age;
    } voice_t;

endpackage

// File: rtl/poly_voice_allocator.sv
// Purpose: maps note-on/off events onto NUM_VOICES slots (match, free, oldest released, oldest gated).
// Latency: accept to gate high NUM_VOICES+1 cycles (free slot), NUM_VOICES+2 (retrigger/steal).
// Backpressure: ev_ready only in IDLE without all_notes_off; one event in flight at a time.
module poly_voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES      = 4,
    parameter int PHASE_ACC_WIDTH = 30,
    parameter int NOTE_W          = 7,
    parameter int AGE_W           = 8
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        ev_valid,
    output logic                                        ev_ready,
    input  logic                                        ev_on,
    input  logic [NOTE_W-1:0]                           ev_note,
    input  logic [PHASE_ACC_WIDTH-1:0]                  ev_fccw,
    input  logic                                        all_notes_off,
    input  logic [NUM_VOICES-1:0]                       voice_idle,
    output logic [NUM_VOICES-1:0]                       voice_gate,
    output logic [NUM_VOICES-1:0][PHASE_ACC_WIDTH-1:0]  voice_fccw,
    output logic [NUM_VOICES-1:0][NOTE_W-1:0]           voice_note,
    output logic [15:0]                                 steal_cnt
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    alloc_state_t state, state_nxt;

    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           ret_idx;
    logic                       lat_on;
    logic [NOTE_W-1:0]          lat_note;
    logic [PHASE_ACC_WIDTH-1:0] lat_fccw;
    logic [AGE_W-1:0]           age [NUM_VOICES];

    logic                       match_vld, free_vld, rel_vld, old_vld;
    logic [IDX_W-1:0]           match_idx, free_idx, rel_idx, old_idx;
    logic [AGE_W-1:0]           rel_age, old_age;

    logic                       tgt_vld, tgt_free, tgt_steal;
    logic [IDX_W-1:0]           tgt_idx;

    assign ev_ready = (state == IDLE) && !all_notes_off;

    // Target choice from the candidates gathered during SCAN.
    always_comb begin
        tgt_vld   = 1'b1;
        tgt_free  = 1'b0;
        tgt_steal = 1'b0;
        tgt_idx   = match_idx;
        if (match_vld) begin
            tgt_idx = match_idx;
        end else if (!lat_on) begin
            tgt_vld = 1'b0;
        end else if (free_vld) begin
            tgt_idx  = free_idx;
            tgt_free = 1'b1;
        end else if (rel_vld) begin
            tgt_idx = rel_idx;
        end else if (old_vld) begin
            tgt_idx   = old_idx;
            tgt_steal = 1'b1;
        end else begin
            tgt_vld = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ev_valid && ev_ready) state_nxt = SCAN;
            SCAN:    if (idx == LAST_IDX) state_nxt = COMMIT;
            COMMIT:  state_nxt = (tgt_vld && lat_on && !tgt_free) ? RETRIG : IDLE;
            RETRIG:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (all_notes_off) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            ret_idx    <= '0;
            lat_on     <= 1'b0;
            lat_note   <= '0;
            lat_fccw   <= '0;
            match_vld  <= 1'b0;
            free_vld   <= 1'b0;
            rel_vld    <= 1'b0;
            old_vld    <= 1'b0;
            match_idx  <= '0;
            free_idx   <= '0;
            rel_idx    <= '0;
            old_idx    <= '0;
            rel_age    <= '0;
            old_age    <= '0;
            voice_gate <= '0;
            voice_fccw <= '0;
            voice_note <= '0;
            steal_cnt  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
        end else begin
            state <= state_nxt;
            if (all_notes_off) begin
                // Panic: silence everything, keep fccw/note so release tails stay in tune.
                voice_gate <= '0;
                for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ev_valid && ev_ready) begin
                            lat_on    <= ev_on;
                            lat_note  <= ev_note;
                            lat_fccw  <= ev_fccw;
                            idx       <= '0;
                            match_vld <= 1'b0;
                            free_vld  <= 1'b0;
                            rel_vld   <= 1'b0;
                            old_vld   <= 1'b0;
                        end
                    end
                    SCAN: begin
                        if (voice_gate[idx]) begin
                            if (!match_vld && voice_note[idx] == lat_note) begin
                                match_vld <= 1'b1;
                                match_idx <= idx;
                            end
                            if (!old_vld || age[idx] > old_age) begin
                                old_vld <= 1'b1;
                                old_idx <= idx;
                                old_age <= age[idx];
                            end
                        end else if (voice_idle[idx]) begin
                            if (!free_vld) begin
                                free_vld <= 1'b1;
                                free_idx <= idx;
                            end
                        end else if (!rel_vld || age[idx] > rel_age) begin
                            rel_vld <= 1'b1;
                            rel_idx <= idx;
                            rel_age <= age[idx];
                        end
                        idx <= idx + 1'b1;
                    end
                    COMMIT: begin
                        if (tgt_vld && lat_on) begin
                            // A reused voice drops its gate for one cycle so the envelope restarts.
                            voice_gate[tgt_idx] <= tgt_free;
                            voice_fccw[tgt_idx] <= lat_fccw;
                            voice_note[tgt_idx] <= lat_note;
                            ret_idx             <= tgt_idx;
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (IDX_W'(i) == tgt_idx) age[i] <= '0;
                                else if (age[i] != AGE_MAX) age[i] <= age[i] + 1'b1;
                            end
                            if (tgt_steal && steal_cnt != 16'hFFFF) steal_cnt <= steal_cnt + 16'd1;
                        end else if (tgt_vld) begin
                            voice_gate[tgt_idx] <= 1'b0;
                        end
                    end
                    RETRIG: voice_gate[ret_idx] <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Directed bench for poly_voice_allocator: event-level voice model plus per-cycle output compare.
module tb_poly_voice_allocator;

    localparam int NV = 4;
    localparam int PW = 30;
    localparam int NW = 7;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     ev_valid = 1'b0;
    logic                     ev_ready;
    logic                     ev_on = 1'b0;
    logic [NW-1:0]            ev_note = '0;
    logic [PW-1:0]            ev_fccw = '0;
    logic                     all_notes_off = 1'b0;
    logic [NV-1:0]            voice_idle = '1;
    logic [NV-1:0]            voice_gate;
    logic [NV-1:0][PW-1:0]    voice_fccw;
    logic [NV-1:0][NW-1:0]    voice_note;
    logic [15:0]              steal_cnt;

    poly_voice_allocator #(
        .NUM_VOICES(NV), .PHASE_ACC_WIDTH(PW), .NOTE_W(NW), .AGE_W(8)
    ) dut (
        .clk(clk), .reset(reset),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
        .ev_note(ev_note), .ev_fccw(ev_fccw),
        .all_notes_off(all_notes_off), .voice_idle(voice_idle),
        .voice_gate(voice_gate), .voice_fccw(voice_fccw),
        .voice_note(voice_note), .steal_cnt(steal_cnt)
    );

    always #5 clk = ~clk;

    // Expected visible state of every voice.
    bit m_gate [NV];
    int m_note [NV];
    int m_fccw [NV];
    int m_age  [NV];
    int m_steal;
    bit m_ready;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 1'b0; m_note[i] = 0; m_fccw[i] = 0; m_age[i] = 0;
        end
        m_steal = 0;
        m_ready = 1'b1;
    endfunction

    // kind: 0 = dropped, 1 = free voice, 2 = reuse (match or released), 3 = steal
    function automatic void pick(input bit on, input int note, output int tgt, output int kind);
        int best;
        tgt = -1; kind = 0;
        for (int i = 0; i < NV; i++)
            if (m_gate[i] && m_note[i] == note) begin tgt = i; kind = 2; return; end
        if (!on) return;
        for (int i = 0; i < NV; i++)
            if (!m_gate[i] && voice_idle[i]) begin tgt = i; kind = 1; return; end
        best = -1;
        for (int i = 0; i < NV; i++)
            if (!m_gate[i] && !voice_idle[i] && m_age[i] > best) begin best = m_age[i]; tgt = i; kind = 2; end
        if (tgt >= 0) return;
        best = -1;
        for (int i = 0; i < NV; i++)
            if (m_gate[i] && m_age[i] > best) begin best = m_age[i]; tgt = i; kind = 3; end
    endfunction

    // abort: 0 = none, 1 = reset pulse mid-scan, 2 = all_notes_off pulse mid-scan
    task automatic send(input bit on, input int note, input int fccw, input int abort);
        int tgt, kind;
        ev_valid = 1'b1; ev_on = on; ev_note = NW'(note); ev_fccw = PW'(fccw);
        @(posedge clk); #1;
        ev_valid = 1'b0;
        m_ready  = 1'b0;
        pick(on, note, tgt, kind);
        if (abort != 0) begin
            repeat (2) @(posedge clk);
            #1;
            if (abort == 1) begin
                reset = 1'b0;
                model_reset();
                @(posedge clk); #1;
                reset = 1'b1;
            end else begin
                all_notes_off = 1'b1;
                @(posedge clk); #1;
                all_notes_off = 1'b0;
                for (int i = 0; i < NV; i++) begin m_gate[i] = 1'b0; m_age[i] = 0; end
                m_ready = 1'b1;
            end
            return;
        end
        repeat (NV + 1) @(posedge clk);
        #1;
        if (kind == 0) begin
            m_ready = 1'b1;
        end else if (!on) begin
            m_gate[tgt] = 1'b0;
            m_ready = 1'b1;
        end else begin
            m_note[tgt] = note;
            m_fccw[tgt] = fccw;
            for (int i = 0; i < NV; i++)
                m_age[i] = (i == tgt) ? 0 : ((m_age[i] < 255) ? m_age[i] + 1 : 255);
            if (kind == 3 && m_steal < 65535) m_steal++;
            if (kind == 1) begin
                m_gate[tgt] = 1'b1;
                m_ready = 1'b1;
            end else begin
                m_gate[tgt] = 1'b0;
                @(posedge clk); #1;
                m_gate[tgt] = 1'b1;
                m_ready = 1'b1;
            end
        end
    endtask

    task automatic panic();
        all_notes_off = 1'b1;
        m_ready = 1'b0;
        @(posedge clk); #1;
        all_notes_off = 1'b0;
        for (int i = 0; i < NV; i++) begin m_gate[i] = 1'b0; m_age[i] = 0; end
        m_ready = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NV; i++) begin
                check($sformatf("gate%0d", i), 64'(voice_gate[i]), 64'(m_gate[i]));
                check($sformatf("note%0d", i), 64'(voice_note[i]), 64'(m_note[i]));
                check($sformatf("fccw%0d", i), 64'(voice_fccw[i]), 64'(m_fccw[i]));
            end
            check("steal_cnt", 64'(steal_cnt), 64'(m_steal));
            check("ev_ready", 64'(ev_ready), 64'(m_ready));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_gate", 64'(voice_gate), 64'h0);
        check("rst_steal", 64'(steal_cnt), 64'h0);
        check("rst_ready", 64'(ev_ready), 64'h1);
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset pulse during scan, then the next event goes through normally.
        send(1'b1, 50, 'h500, 1);
        check("t1_gate", 64'(voice_gate), 64'h0);
        check("t1_ready", 64'(ev_ready), 64'h1);

        send(1'b1, 60, 'h1000, 0);
        check("t2_gate", 64'(voice_gate), 64'b0001);
        check("t2_note0", 64'(voice_note[0]), 64'd60);
        check("t2_fccw0", 64'(voice_fccw[0]), 64'h1000);
        send(1'b0, 60, 0, 0);
        check("t2_off", 64'(voice_gate), 64'h0);
        check("t2_hold_note", 64'(voice_note[0]), 64'd60);

        // Fill all voices, then steal the oldest with every envelope busy.
        send(1'b1, 60, 'h1000, 0);
        send(1'b1, 62, 'h1100, 0);
        send(1'b1, 64, 'h1200, 0);
        send(1'b1, 65, 'h1300, 0);
        voice_idle = '0;
        send(1'b1, 67, 'h1400, 0);
        check("t3_gate", 64'(voice_gate), 64'b1111);
        check("t3_note0", 64'(voice_note[0]), 64'd67);
        check("t3_note3", 64'(voice_note[3]), 64'd65);
        check("t3_steal", 64'(steal_cnt), 64'd1);

        // Duplicate note-on retriggers the same voice.
        panic();
        check("t4_panic", 64'(voice_gate), 64'h0);
        voice_idle = '1;
        send(1'b1, 60, 'h2000, 0);
        send(1'b1, 60, 'h2100, 0);
        check("t4_gate", 64'(voice_gate), 64'b0001);
        check("t4_fccw0", 64'(voice_fccw[0]), 64'h2100);
        check("t4_steal", 64'(steal_cnt), 64'd1);

        // Note-off for an unheld note changes nothing.
        send(1'b0, 70, 0, 0);
        check("t5_gate", 64'(voice_gate), 64'b0001);
        check("t5_ready", 64'(ev_ready), 64'h1);

        // Panic during scan discards the in-flight note-on.
        send(1'b1, 72, 'h3000, 2);
        check("t6_gate", 64'(voice_gate), 64'h0);
        check("t6_notes", 64'(voice_note), 64'({7'd65, 7'd64, 7'd62, 7'd60}));

        // All voices released but still sounding: oldest released is reused, not stolen.
        voice_idle = '0;
        send(1'b1, 80, 'h4000, 0);
        check("t7_gate", 64'(voice_gate), 64'b0001);
        check("t7_note0", 64'(voice_note[0]), 64'd80);
        check("t7_steal", 64'(steal_cnt), 64'd1);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
